sdf_bf2_stage_ifft: RTL and testbench

Radix-2 single-path delay-feedback (SDF) butterfly stage for the 64-point mixed-radix IFFT pipeline. It sits directly upstream of the trivial (×1 / ×j) multiplier. It consumes one complex sample per valid cycle and produces butterfly sums and differences in SDF order. It also generates the 6-bit `address` select the downstream trivial multiplier consumes, registered in lockstep with the data.

---
 rtl/sdf_bf2_stage_ifft_if.sv | 22 ++
 rtl/sdf_bf2_stage_ifft.sv | 78 +++++++
 tb/tb_sdf_bf2_stage_ifft.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sdf_bf2_stage_ifft_if.sv
// sdf_bf2_stage_ifft_if: sample stream into and butterfly stream out of the SDF radix-2 stage.
interface sdf_bf2_stage_ifft_if #(
    parameter int DATA_WIDTH = 18
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_r;
    logic signed [DATA_WIDTH-1:0] in_i;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] out_r;
    logic signed [DATA_WIDTH-1:0] out_i;
    logic [5:0]                   address;

    modport master (
        output in_valid, in_r, in_i,
        input  out_valid, out_r, out_i, address
    );

    modport slave (
        input  in_valid, in_r, in_i,
        output out_valid, out_r, out_i, address
    );
endinterface

// File: rtl/sdf_bf2_stage_ifft.sv
// sdf_bf2_stage_ifft: radix-2 SDF butterfly with trivial-multiplier address; SDF_BF_SAT_EN selects saturation over wrap.
module sdf_bf2_stage_ifft #(
    parameter int INTEGER_SIZE = 6,
    parameter int FRACT_SIZE   = 12,
    parameter int DELAY        = 16
) (
    input logic                 clk,
    input logic                 rst,
    sdf_bf2_stage_ifft_if.slave bus
);
    localparam int DW = INTEGER_SIZE + FRACT_SIZE;
    localparam int CW = $clog2(DELAY) + 1;
    localparam int OW = $clog2(4 * DELAY);

    logic signed [DW-1:0] line_r [DELAY];
    logic signed [DW-1:0] line_i [DELAY];
    logic [CW-1:0]        icnt;
    logic [OW-1:0]        ocnt;
    logic                 primed;
    logic                 phase;
    logic [DW:0]          sum_r, sum_i, dif_r, dif_i;
    logic signed [DW-1:0] res_r, res_i, push_r, push_i;

    function automatic logic signed [DW-1:0] fit(input logic [DW:0] v);
`ifdef SDF_BF_SAT_EN
        return (v[DW] != v[DW-1]) ? {v[DW], {(DW-1){~v[DW]}}} : v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction

    // line index 0 is the oldest entry, i.e. the value leaving this cycle
    always_comb begin
        phase  = icnt[CW-1];
        sum_r  = {line_r[0][DW-1], line_r[0]} + {bus.in_r[DW-1], bus.in_r};
        sum_i  = {line_i[0][DW-1], line_i[0]} + {bus.in_i[DW-1], bus.in_i};
        dif_r  = {line_r[0][DW-1], line_r[0]} - {bus.in_r[DW-1], bus.in_r};
        dif_i  = {line_i[0][DW-1], line_i[0]} - {bus.in_i[DW-1], bus.in_i};
        res_r  = phase ? fit(sum_r) : line_r[0];
        res_i  = phase ? fit(sum_i) : line_i[0];
        push_r = phase ? fit(dif_r) : bus.in_r;
        push_i = phase ? fit(dif_i) : bus.in_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            icnt          <= '0;
            ocnt          <= '0;
            primed        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
            bus.address   <= '0;
            for (int k = 0; k < DELAY; k++) begin
                line_r[k] <= '0;
                line_i[k] <= '0;
            end
        end else begin
            bus.out_valid <= bus.in_valid & primed;
            if (bus.in_valid) begin
                icnt <= icnt + CW'(1);
                if (icnt == CW'(DELAY - 1))
                    primed <= 1'b1;
                if (primed)
                    ocnt <= ocnt + OW'(1);
                bus.out_r   <= res_r;
                bus.out_i   <= res_i;
                bus.address <= {5'd0, primed & (&ocnt[OW-1 -: 2])};
                for (int k = 0; k < DELAY - 1; k++) begin
                    line_r[k] <= line_r[k+1];
                    line_i[k] <= line_i[k+1];
                end
                line_r[DELAY-1] <= push_r;
                line_i[DELAY-1] <= push_i;
            end
        end
    end
endmodule

// File: tb/tb_sdf_bf2_stage_ifft.sv
// tb_sdf_bf2_stage_ifft: directed vectors for the SDF butterfly stage at DELAY=2 and DELAY=16.
module tb_sdf_bf2_stage_ifft;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    sdf_bf2_stage_ifft_if #(.DATA_WIDTH(18)) bus2 ();
    sdf_bf2_stage_ifft_if #(.DATA_WIDTH(18)) bus16 ();

    sdf_bf2_stage_ifft #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .DELAY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sdf_bf2_stage_ifft dut16 (.clk(clk), .rst(rst), .bus(bus16));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input int r, input int i);
        bus2.in_valid = v;
        bus2.in_r = 18'(r);
        bus2.in_i = 18'(i);
        tick();
    endtask

    task automatic drive16(input logic v, input int r, input int i);
        bus16.in_valid = v;
        bus16.in_r = 18'(r);
        bus16.in_i = 18'(i);
        tick();
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        bus2.in_valid = 1'b0;
        bus16.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic int ramp(input int k);
        return k < 64 ? k * 64 : 0;
    endfunction

    task automatic test_reset;
        bus2.in_valid = 1'b1;
        bus2.in_r = 18'd4096;
        bus16.in_valid = 1'b1;
        bus16.in_r = 18'd4096;
        tick();
        apply_reset();
        n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", bus2.out_valid); end
        n_checks++; if (bus2.out_r !== 18'd0) begin n_fail++; $display("FAIL reset out_r got %0d exp 0", bus2.out_r); end
        n_checks++; if (bus2.out_i !== 18'd0) begin n_fail++; $display("FAIL reset out_i got %0d exp 0", bus2.out_i); end
        n_checks++; if (bus2.address !== 6'd0) begin n_fail++; $display("FAIL reset address got %0d exp 0", bus2.address); end
        n_checks++; if (bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset16 out_valid got %b exp 0", bus16.out_valid); end
        n_checks++; if (bus16.out_r !== 18'd0) begin n_fail++; $display("FAIL reset16 out_r got %0d exp 0", bus16.out_r); end
        n_checks++; if (bus16.address !== 6'd0) begin n_fail++; $display("FAIL reset16 address got %0d exp 0", bus16.address); end
    endtask

    task automatic test_basic;
        int x[6] = '{4096, 8192, 12288, 16384, 0, 0};
        int e[4] = '{16384, 24576, -8192, -8192};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive2(1'b1, x[k], 0);
            n_checks++; if (bus2.out_valid !== (k >= 2 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL basic out_valid k=%0d got %b", k, bus2.out_valid); end
            if (k >= 2) begin
                n_checks++; if (bus2.out_r !== 18'(e[k-2])) begin n_fail++; $display("FAIL basic out_r k=%0d got %0d exp %0d", k, bus2.out_r, e[k-2]); end
                n_checks++; if (bus2.out_i !== 18'd0) begin n_fail++; $display("FAIL basic out_i k=%0d got %0d exp 0", k, bus2.out_i); end
            end
        end
    endtask

    task automatic test_imag;
        int x[6] = '{4096, 8192, 12288, 16384, 0, 0};
        int e[4] = '{16384, 24576, -8192, -8192};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive2(1'b1, 0, x[k]);
            if (k >= 2) begin
                n_checks++; if (bus2.out_i !== 18'(e[k-2])) begin n_fail++; $display("FAIL imag out_i k=%0d got %0d exp %0d", k, bus2.out_i, e[k-2]); end
                n_checks++; if (bus2.out_r !== 18'd0) begin n_fail++; $display("FAIL imag out_r k=%0d got %0d exp 0", k, bus2.out_r); end
            end
        end
    endtask

    task automatic test_stall;
        logic v[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        int   x[9]  = '{4096, 8192, 12288, 777, 777, 777, 16384, 0, 0};
        logic ev[9] = '{0, 0, 1, 0, 0, 0, 1, 1, 1};
        int   er[9] = '{0, 0, 16384, 16384, 16384, 16384, 24576, -8192, -8192};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive2(v[k], x[k], 0);
            n_checks++; if (bus2.out_valid !== ev[k]) begin n_fail++; $display("FAIL stall out_valid k=%0d got %b exp %b", k, bus2.out_valid, ev[k]); end
            if (k >= 2) begin
                n_checks++; if (bus2.out_r !== 18'(er[k])) begin n_fail++; $display("FAIL stall out_r k=%0d got %0d exp %0d", k, bus2.out_r, er[k]); end
                n_checks++; if (bus2.address !== 6'd0) begin n_fail++; $display("FAIL stall address k=%0d got %0d exp 0", k, bus2.address); end
            end
        end
    endtask

    task automatic test_address;
        int ea[16] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        apply_reset();
        drive2(1'b1, 0, 0);
        drive2(1'b1, 0, 0);
        for (int j = 0; j < 16; j++) begin
            drive2(1'b1, 0, 0);
            n_checks++; if (bus2.out_valid !== 1'b1) begin n_fail++; $display("FAIL address out_valid j=%0d got %b exp 1", j, bus2.out_valid); end
            n_checks++; if (bus2.address !== 6'(ea[j])) begin n_fail++; $display("FAIL address j=%0d got %0d exp %0d", j, bus2.address, ea[j]); end
            if (j == 6) begin
                drive2(1'b0, 0, 0);
                n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL address stall out_valid got %b exp 0", bus2.out_valid); end
                n_checks++; if (bus2.address !== 6'd1) begin n_fail++; $display("FAIL address stall hold got %0d exp 1", bus2.address); end
            end
        end
    endtask

    task automatic test_overflow;
        int x[6] = '{122880, -122880, 122880, -122880, 0, 0};
`ifdef SDF_BF_SAT_EN
        int e[4] = '{131071, -131072, 0, 0};
`else
        int e[4] = '{-16384, 16384, 0, 0};
`endif
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive2(1'b1, x[k], -x[k]);
            if (k >= 2) begin
                n_checks++; if (bus2.out_r !== 18'(e[k-2])) begin n_fail++; $display("FAIL overflow out_r k=%0d got %0d exp %0d", k, bus2.out_r, e[k-2]); end
                n_checks++; if (bus2.out_i !== 18'(e[(k-2)^1])) begin n_fail++; $display("FAIL overflow out_i k=%0d got %0d exp %0d", k, bus2.out_i, e[(k-2)^1]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        drive2(1'b1, 4096, 0);
        drive2(1'b1, 8192, 0);
        drive2(1'b1, 12288, 0);
        n_checks++; if (bus2.out_r !== 18'd16384) begin n_fail++; $display("FAIL midreset pre out_r got %0d exp 16384", bus2.out_r); end
        rst = 1'b0;
        drive2(1'b1, 4096, 4096);
        rst = 1'b1;
        n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid got %b exp 0", bus2.out_valid); end
        n_checks++; if (bus2.out_r !== 18'd0) begin n_fail++; $display("FAIL midreset out_r got %0d exp 0", bus2.out_r); end
        n_checks++; if (bus2.out_i !== 18'd0) begin n_fail++; $display("FAIL midreset out_i got %0d exp 0", bus2.out_i); end
        n_checks++; if (bus2.address !== 6'd0) begin n_fail++; $display("FAIL midreset address got %0d exp 0", bus2.address); end
        for (int k = 0; k < 4; k++) begin
            drive2(1'b1, 4096, 0);
            n_checks++; if (bus2.out_valid !== (k >= 2 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL midreset restart out_valid k=%0d got %b", k, bus2.out_valid); end
            if (k >= 2) begin
                n_checks++; if (bus2.out_r !== 18'd8192) begin n_fail++; $display("FAIL midreset restart out_r k=%0d got %0d exp 8192", k, bus2.out_r); end
            end
        end
    endtask

    task automatic test_default_frame;
        int er;
        apply_reset();
        for (int k = 0; k <= 80; k++) begin
            drive16(1'b1, ramp(k), -ramp(k));
            n_checks++; if (bus16.out_valid !== (k >= 16 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL frame out_valid k=%0d got %b", k, bus16.out_valid); end
            if (k >= 16) begin
                er = ((k / 16) % 2 == 1) ? ramp(k - 16) + ramp(k) : ramp(k - 32) - ramp(k - 16);
                n_checks++; if (bus16.out_r !== 18'(er)) begin n_fail++; $display("FAIL frame out_r k=%0d got %0d exp %0d", k, bus16.out_r, er); end
                n_checks++; if (bus16.out_i !== 18'(-er)) begin n_fail++; $display("FAIL frame out_i k=%0d got %0d exp %0d", k, bus16.out_i, -er); end
                n_checks++; if (bus16.address !== ((k - 16) % 64 >= 48 ? 6'd1 : 6'd0)) begin n_fail++; $display("FAIL frame address out=%0d got %0d", k - 16, bus16.address); end
            end
        end
    endtask

    initial begin
        bus2.in_valid = 1'b0;
        bus2.in_r = '0;
        bus2.in_i = '0;
        bus16.in_valid = 1'b0;
        bus16.in_r = '0;
        bus16.in_i = '0;
        test_reset();
        test_basic();
        test_imag();
        test_stall();
        test_address();
        test_overflow();
        test_reset_mid();
        test_default_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
